error_combiner_sequencer: RTL



---
 rtl/adpll_pkg.sv | 29 ++
 rtl/error_combiner_sequencer_if.sv | 33 +++
 rtl/weighted_mac.sv | 37 +++
 rtl/error_combiner_sequencer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
`default_nettype none
// ============================================================================
// adpll_pkg : shared types and helpers for the ADPLL error combiner
// Rev 1.0
// ============================================================================
package adpll_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Clip a sign-extended value into the signed range of 'width' bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/error_combiner_sequencer_if.sv
`default_nettype none
// ============================================================================
// error_combiner_sequencer_if : channel inputs and combined-error outputs
// Rev 1.0
// ============================================================================
interface error_combiner_sequencer_if
  import adpll_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 4,
  parameter int ERROR_WIDTH  = 8
);
  logic                           sample;
  logic [NUM_CH-1:0]              ch_en;
  logic signed [WEIGHT_WIDTH-1:0] weight [NUM_CH];
  logic signed [ERROR_WIDTH-1:0]  error  [NUM_CH];
  logic                           clear_ovr;
  logic signed [ERROR_WIDTH-1:0]  error_comb;
  logic                           valid;
  logic                           busy;
  logic                           sat;
  logic                           overrun;

  modport master (
    output sample, ch_en, weight, error, clear_ovr,
    input  error_comb, valid, busy, sat, overrun
  );

  modport slave (
    input  sample, ch_en, weight, error, clear_ovr,
    output error_comb, valid, busy, sat, overrun
  );
endinterface
`default_nettype wire

// File: rtl/weighted_mac.sv
`default_nettype none
// ============================================================================
// weighted_mac : shared signed multiply-accumulate with gated product
// Rev 1.0
// ============================================================================
module weighted_mac #(
  parameter int ERROR_WIDTH  = 8,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                                       clk_i,
  input  logic                                       reset_i,
  input  logic                                       i_clear,
  input  logic                                       i_acc_en,
  input  logic                                       i_gate,
  input  logic signed [ERROR_WIDTH-1:0]              i_err,
  input  logic signed [WEIGHT_WIDTH-1:0]             i_weight,
  output logic signed [ERROR_WIDTH+WEIGHT_WIDTH+1:0] o_acc
);
  localparam int PW = ERROR_WIDTH + WEIGHT_WIDTH;

  logic signed [PW-1:0] w_err_x;
  logic signed [PW-1:0] w_weight_x;
  logic signed [PW-1:0] w_prod;

  assign w_err_x    = {{WEIGHT_WIDTH{i_err[ERROR_WIDTH-1]}}, i_err};
  assign w_weight_x = {{ERROR_WIDTH{i_weight[WEIGHT_WIDTH-1]}}, i_weight};
  assign w_prod     = i_gate ? (w_err_x * w_weight_x) : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i || i_clear) begin
      o_acc <= '0;
    end else if (i_acc_en) begin
      o_acc <= o_acc + {{2{w_prod[PW-1]}}, w_prod};
    end
  end
endmodule
`default_nettype wire

// File: rtl/error_combiner_sequencer.sv
`default_nettype none
// ============================================================================
// error_combiner_sequencer : time-multiplexed weighted loop-error combiner
// Rev 1.0
// ============================================================================
module error_combiner_sequencer
  import adpll_pkg::*;
#(
  parameter int WEIGHT_WIDTH = 4,
  parameter int ERROR_WIDTH  = 8,
  parameter int SHIFT        = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  error_combiner_sequencer_if.slave  bus
);
  localparam int AW = ERROR_WIDTH + WEIGHT_WIDTH + 2;

  seq_state_t                     r_state;
  seq_state_t                     w_next;
  logic [1:0]                     r_idx;
  logic [NUM_CH-1:0]              r_en;
  logic signed [ERROR_WIDTH-1:0]  r_err [NUM_CH];
  logic signed [WEIGHT_WIDTH-1:0] r_w   [NUM_CH];
  logic signed [ERROR_WIDTH-1:0]  r_comb;
  logic                           r_valid;
  logic                           r_sat;
  logic                           r_ovr;
  logic                           w_start;
  logic                           w_acc_en;
  logic                           w_done;
  logic signed [AW-1:0]           w_acc;
  logic signed [AW-1:0]           w_shifted;
  logic signed [63:0]             w_wide;
  logic                           w_busy;

  assign w_busy = (r_state != IDLE);

  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_acc_en = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.sample) begin
          w_start = 1'b1;
          w_next  = MAC;
        end
      end
      MAC: begin
        w_acc_en = 1'b1;
        if (r_idx == 2'd3) w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_en    <= '0;
      r_comb  <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
      r_ovr   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_err[i] <= '0;
        r_w[i]   <= '0;
      end
    end else begin
      r_state <= w_next;
      r_valid <= w_done;
      if (w_start) begin
        r_idx <= '0;
        r_en  <= bus.ch_en;
        for (int i = 0; i < NUM_CH; i++) begin
          r_err[i] <= bus.error[i];
          r_w[i]   <= bus.weight[i];
        end
      end else if (w_acc_en) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_done) begin
        r_comb <= ERROR_WIDTH'(saturate(w_wide, ERROR_WIDTH));
        r_sat  <= (saturate(w_wide, ERROR_WIDTH) != w_wide);
      end
      // A new overrun takes priority over a simultaneous clear.
      if (w_busy && bus.sample) r_ovr <= 1'b1;
      else if (bus.clear_ovr)   r_ovr <= 1'b0;
    end
  end

  weighted_mac #(
    .ERROR_WIDTH  (ERROR_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH)
  ) u_mac (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .i_clear  (w_start),
    .i_acc_en (w_acc_en),
    .i_gate   (r_en[r_idx]),
    .i_err    (r_err[r_idx]),
    .i_weight (r_w[r_idx]),
    .o_acc    (w_acc)
  );

  assign w_shifted = w_acc >>> SHIFT;
  assign w_wide    = {{(64 - AW){w_shifted[AW-1]}}, w_shifted};

  assign bus.error_comb = r_comb;
  assign bus.valid      = r_valid;
  assign bus.busy       = w_busy;
  assign bus.sat        = r_sat;
  assign bus.overrun    = r_ovr;
endmodule
`default_nettype wire
